// File: rtl/uart_axis_pkg.sv
// Shared types and helpers for the UART receive to AXI-Stream path.
// The UART_RX_PARITY_EN macro (8E1 framing) is consumed by uart_rx_axis_fifo.
package uart_axis_pkg;

    // Terminator byte that marks the last beat of a message
    localparam logic [7:0] LAST_CHAR_DEFAULT = 8'h0A;

    // Receive FSM states; PARITY is only reachable when parity is enabled
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

    // One FIFO entry: byte plus its precomputed terminator flag
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_beat_t;

    // Clock cycles per serial bit (integer division)
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/axis_rx_fifo.sv
// First-word-fall-through FIFO holding {last, data} beats for the AXIS master.
// Head entry is visible on rd_data whenever empty is low.
module axis_rx_fifo
    import uart_axis_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  rx_beat_t                wr_data,
    input  logic                    rd_en,
    output rx_beat_t                rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    rx_beat_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;
    logic [CW-1:0]     count_next;

    // Accept a write when not full, or when full but the head leaves this cycle
    always_comb begin
        do_rd      = rd_en && !empty;
        do_wr      = wr_en && (!full || do_rd);
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_next = count - 1'b1;
        end
    end

    // Storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally modulo the power-of-two depth; flags follow count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding an FWFT FIFO
// presented as an AXI-Stream master; m_axis_last flags the terminator byte.
module uart_rx_axis_fifo
    import uart_axis_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  LAST_CHAR = LAST_CHAR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rx,
    output logic [7:0]              m_axis_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic                    m_axis_last,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    frame_err,
    output logic                    overflow,
    output logic                    parity_err
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CNT_W = $clog2(CPB);

    logic              rx_meta;
    logic              rx_sync;
    rx_state_e         state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              par_bad;
    logic              push;
    rx_beat_t          beat;
    rx_beat_t          head;
    logic              full;
    logic              empty;
    logic              pop;

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM: centre-samples each bit and issues a one-cycle push strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bad   <= 1'b0;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        par_bad  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_W'(HALF - 1)) begin
                        baud_cnt <= '0;
                        state    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_W'(CPB - 1)) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    // Even parity: the parity bit must equal the XOR of the data bits
                    if (baud_cnt == CNT_W'(CPB - 1)) begin
                        baud_cnt   <= '0;
                        par_bad    <= rx_sync ^ (^shift);
                        parity_err <= rx_sync ^ (^shift);
                        state      <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == CNT_W'(CPB - 1)) begin
                        baud_cnt <= '0;
                        if (rx_sync) begin
                            push  <= !par_bad;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A low stop bit means the line is mid-break; wait for idle
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    assign beat.last = (shift == LAST_CHAR);
    assign beat.data = shift;
    assign pop       = m_axis_valid && m_axis_ready;

    // Sticky drop flag: a push arrived while full and nothing left the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    axis_rx_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (beat),
        .rd_en   (m_axis_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign m_axis_valid = !empty;
    assign m_axis_data  = head.data;
    assign m_axis_last  = head.last;

endmodule
